// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and IF/ID capture stage with redirect/stall/halt arbitration.
// Optional FETCH_PERF_EN adds fetch_count/stall_count performance counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS  = 64,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] inst_in,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [1:0]  fetch_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned WRAP_BYTES = IMEM_WORDS * 4;
  localparam logic [31:0] WRAP_ADDR  = 32'(WRAP_BYTES);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    A_NONE, A_REDIRECT, A_STALL, A_HALT, A_FETCH
  } action_t;

  state_t      state, state_nxt;
  action_t     action;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] inst_nxt, pc4_nxt;
  logic        valid_nxt, halted_nxt;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign fetch_state = state;

  // Per-cycle arbitration: redirect > stall > halt detect > sequential fetch.
  always_comb begin
    action = A_NONE;
    if (state == S_FETCH || state == S_STALL) begin
      if (jump || branch_taken)                  action = A_REDIRECT;
      else if (stall)                            action = A_STALL;
      else if (inst_in[31:26] == HALT_OPCODE)    action = A_HALT;
      else                                       action = A_FETCH;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    inst_nxt   = if_id_inst;
    pc4_nxt    = if_id_pc4;
    valid_nxt  = if_id_valid;
    halted_nxt = halted;
    unique case (state)
      S_INIT: state_nxt = S_FETCH;
      S_HALT: state_nxt = S_HALT;
      default: begin
        unique case (action)
          A_REDIRECT: begin
            pc_nxt    = (jump ? jump_target : branch_target) & ~32'd3;
            inst_nxt  = '0;
            valid_nxt = 1'b0;
            state_nxt = S_FETCH;
          end
          A_STALL: state_nxt = S_STALL;
          A_HALT: begin
            valid_nxt  = 1'b0;
            halted_nxt = 1'b1;
            state_nxt  = S_HALT;
          end
          A_FETCH: begin
            inst_nxt  = inst_in;
            pc4_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = (pc_plus4 == WRAP_ADDR) ? '0 : pc_plus4;
            state_nxt = S_FETCH;
          end
          default: state_nxt = state;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      pc          <= RESET_PC;
      if_id_inst  <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_inst  <= inst_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= valid_nxt;
      halted      <= halted_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  // Counters only move on their own action, so HALT freezes them naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (action == A_FETCH) fetch_count <= fetch_count + 32'd1;
      if (action == A_STALL) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
